// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues imem word requests, buffers
// returned words for decode. Define FETCH_PERF_EN for perf counters.
module fetch_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = 32'h0100_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  // drop can grow across back-to-back redirects; keep headroom
  localparam int DW = PW + 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  state_t state;
  state_t state_nx;

  logic [AWIDTH-1:0] fpc;
  logic [CW-1:0]     live;
  logic [DW-1:0]     drop;
  logic [DW-1:0]     drop_nx;

  entry_t            fifo [FIFO_DEPTH];
  logic [PW-1:0]     rd;
  logic [PW-1:0]     wr;
  logic [CW-1:0]     cnt;

  logic [AWIDTH-1:0] tag [FIFO_DEPTH];
  logic [PW-1:0]     trd;
  logic [PW-1:0]     twr;

  logic [CW:0]       used;
  logic              credit_ok;
  logic              acc;
  logic              stale;
  logic              fresh;
  logic              push;
  logic              pop;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  assign used      = {1'b0, cnt} + {1'b0, live};
  assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

  assign imem_req_valid_o = (state != BOOT) && credit_ok;
  assign imem_req_addr_o  = fpc;

  assign acc   = imem_req_valid_o && imem_req_ready_i;
  assign stale = imem_rsp_valid_i && (drop != '0);
  assign fresh = imem_rsp_valid_i && (drop == '0);
  assign push  = fresh && !redirect_i;
  assign pop   = dec_valid_o && dec_ready_i && !redirect_i;

  assign dec_valid_o = (cnt != '0);
  assign pc_o        = fifo[rd].pc;
  assign insn_o      = fifo[rd].insn;

  // stale-response budget: redirect turns every outstanding request stale
  always_comb begin
    drop_nx = drop;
    if (redirect_i) begin
      drop_nx = drop + DW'(live) + DW'(acc)
              - DW'(imem_rsp_valid_i);
    end else if (stale) begin
      drop_nx = drop - 1'b1;
    end
  end

  // next state: leave BOOT after one cycle, DRAIN while stale work remains
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:       state_nx = RUN;
      RUN, DRAIN: state_nx = (drop_nx != '0) ? DRAIN : RUN;
      default:    state_nx = BOOT;
    endcase
  end

  // fetch PC, credit and state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      fpc   <= RESET_PC;
      live  <= '0;
      drop  <= '0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      if (redirect_i) begin
        fpc  <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
        live <= '0;
      end else begin
        if (acc) fpc <= fpc + AWIDTH'(4);
        live <= live + CW'(acc) - CW'(fresh);
      end
    end
  end

  // PC tags of live requests, consumed in order by fresh responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trd <= '0;
      twr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tag[i] <= '0;
    end else if (redirect_i) begin
      trd <= '0;
      twr <= '0;
    end else begin
      if (acc) begin
        tag[twr] <= fpc;
        twr      <= twr + 1'b1;
      end
      if (fresh) trd <= trd + 1'b1;
    end
  end

  // instruction buffer toward decode; redirect clears and voids a pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else if (redirect_i) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        fifo[wr] <= '{pc: tag[trd], insn: imem_rsp_data_i};
        wr       <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  // credit check must keep the buffer from overflowing
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !pop && (cnt == CW'(FIFO_DEPTH)))
  );
`endif

`ifdef FETCH_PERF_EN
  // words delivered into the buffer, and decode-starved cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_o  <= '0;
      perf_bubble_cnt_o <= '0;
    end else begin
      if (push) perf_fetch_cnt_o <= perf_fetch_cnt_o + 1'b1;
      if ((state != BOOT) && dec_ready_i && !dec_valid_o)
        perf_bubble_cnt_o <= perf_bubble_cnt_o + 1'b1;
    end
  end
`endif

endmodule
